// File: rtl/hd44780_ram_sequencer.sv
// Walks a command list held in the HD44780 RAM, issuing bytes to the LCD byte
// driver with programmed delays, and gates host writes to the RAM while running.
module hd44780_ram_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DELAY_UNIT = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data,
    output logic                  host_ack,
    output logic                  lcd_stb,
    output logic                  lcd_rs,
    output logic [7:0]            lcd_data,
    input  logic                  lcd_busy
);

    // Wide enough to hold 4095 * DELAY_UNIT without overflow.
    localparam int CW = 13 + $clog2(DELAY_UNIT);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_RD, S_DECODE, S_ISSUE, S_DELAY, S_NEXT, S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pointer;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0] pointer_inc;
    logic                  cmd_rs;
    logic [7:0]            cmd_byte;
    logic [CW-1:0]         delay_cnt;
    logic [CW-1:0]         delay_load;
    logic                  unused_bits;

    assign ram_we      = host_we & ~busy;
    assign host_ack    = ram_we;
    assign ram_waddr   = host_addr;
    assign ram_din     = host_data;

    assign pointer_inc = pointer + ADDR_WIDTH'(1);
    assign delay_load  = CW'(ram_dout[11:0]) * CW'(DELAY_UNIT) - CW'(1);
    // Bits [13:12] and everything above bit 15 carry no meaning in a command word.
    assign unused_bits = ^ram_dout[DATA_WIDTH-1:12];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            lcd_stb   <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            ram_raddr <= '0;
            pointer   <= '0;
            base_addr <= '0;
            cmd_rs    <= 1'b0;
            cmd_byte  <= 8'h00;
            delay_cnt <= '0;
        end else begin
            done    <= 1'b0;
            lcd_stb <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pointer   <= start_addr;
                        base_addr <= start_addr;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ram_raddr <= pointer;
                    state     <= S_WAIT_RD;
                end
                S_WAIT_RD: state <= S_DECODE;
                S_DECODE: begin
                    cmd_rs   <= ram_dout[8];
                    cmd_byte <= ram_dout[7:0];
                    if (ram_dout[15]) begin
                        state <= S_DONE;
                    end else if (ram_dout[14]) begin
                        if (ram_dout[11:0] == 12'd0) begin
                            state <= S_NEXT;
                        end else begin
                            delay_cnt <= delay_load;
                            state     <= S_DELAY;
                        end
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!lcd_busy) begin
                        lcd_stb  <= 1'b1;
                        lcd_rs   <= cmd_rs;
                        lcd_data <= cmd_byte;
                        state    <= S_NEXT;
                    end
                end
                S_DELAY: begin
                    if (delay_cnt == '0) begin
                        state <= S_NEXT;
                    end else begin
                        delay_cnt <= delay_cnt - CW'(1);
                    end
                end
                S_NEXT: begin
                    pointer <= pointer_inc;
                    // Coming back round to the start means the list had no END word.
                    if (pointer_inc == base_addr) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_ram_sequencer.sv
// Bench for hd44780_ram_sequencer: RAM and byte-driver models, a list-walking
// reference model feeding an expected-byte queue, directed and random lists.
module tb_hd44780_ram_sequencer;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int DU = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          busy, done, err;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_dout = '0;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_din;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_data = '0;
    logic          host_ack;
    logic          lcd_stb, lcd_rs;
    logic [7:0]    lcd_data;
    logic          lcd_busy;

    always #5 clk = ~clk;

    hd44780_ram_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DELAY_UNIT(DU)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .busy(busy), .done(done), .err(err),
        .ram_raddr(ram_raddr), .ram_dout(ram_dout), .ram_we(ram_we),
        .ram_waddr(ram_waddr), .ram_din(ram_din),
        .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
        .host_ack(host_ack), .lcd_stb(lcd_stb), .lcd_rs(lcd_rs),
        .lcd_data(lcd_data), .lcd_busy(lcd_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [8:0]    exp_q[$];
    logic [8:0]    last_exp = '0;
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] ref_mem [0:255];
    int  busy_max = 0;
    int  busy_cnt = 0;
    logic force_busy = 1'b0;
    int  stb_total = 0;
    int  done_cnt = 0;
    int  first_stb_cyc = -1;
    int  t_start = 0;
    bit  exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read RAM model.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        ram_dout <= mem[ram_raddr];
    end

    assign lcd_busy = force_busy | (busy_cnt != 0);

    // Byte-driver model and strobe/done monitor.
    always @(negedge clk) begin
        if (lcd_stb) begin
            check("stb_busy", lcd_busy, 0);
            stb_total++;
            if (first_stb_cyc < 0) first_stb_cyc = cyc;
            check("stb_count", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                last_exp = exp_q.pop_front();
                check("stb_byte", {lcd_rs, lcd_data}, last_exp);
            end
        end
        if (busy_cnt > 0) busy_cnt--;
        if (lcd_stb && busy_max > 0) busy_cnt = $urandom_range(busy_max, 1);
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the list is a sequence of words from sa; bytes are sent, delays
    // send nothing, END stops cleanly, running all the way round is an error.
    task automatic build_expect(input logic [AW-1:0] sa);
        logic [DW-1:0] w;
        exp_q.delete();
        exp_err = 1'b1;
        for (int n = 0; n < 256; n++) begin
            w = ref_mem[(int'(sa) + n) % 256];
            if (w[15]) begin
                exp_err = 1'b0;
                break;
            end
            if (!w[14]) exp_q.push_back({w[8], w[7:0]});
        end
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit exp_ack);
        step();
        host_we = 1'b1;
        host_addr = a;
        host_data = d;
        #1;
        check("host_ack", host_ack, exp_ack);
        if (exp_ack) ref_mem[a] = d;
        step();
        host_we = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] sa);
        step();
        start = 1'b1;
        start_addr = sa;
        t_start = cyc;
        first_stb_cyc = -1;
        step();
        start = 1'b0;
        check("busy_set", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < budget) begin
            step();
            n++;
        end
        check("done_seen", done_cnt != base, 1);
        check("done_pulse", done, 0);
        check("busy_end", busy, 0);
        check("err_end", err, exp_err);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_list(input logic [AW-1:0] sa, input int budget);
        build_expect(sa);
        pulse_start(sa);
        wait_done(budget);
    endtask

    initial begin
        int s0;
        int base;
        logic [DW-1:0] w;
        logic [AW-1:0] sa;

        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h8000;
            ref_mem[i] = 16'h8000;
        end

        reset = 1'b1;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_stb", lcd_stb, 0);
        check("rst_lcd", {lcd_rs, lcd_data}, 0);
        check("rst_raddr", ram_raddr, 0);
        reset = 1'b0;
        step();

        // Two bytes then END, driver idle.
        host_write(8'h10, 16'h0128, 1);
        host_write(8'h11, 16'h0041, 1);
        host_write(8'h12, 16'h8000, 1);
        s0 = stb_total;
        run_list(8'h10, 200);
        check("first_lat", first_stb_cyc - (t_start + 1), 4);
        check("two_stb", stb_total - s0, 2);
        check("lcd_hold", {lcd_rs, lcd_data}, last_exp);

        // Delay of 3 ticks before a byte.
        host_write(8'h00, 16'h4003, 1);
        host_write(8'h01, 16'h00AA, 1);
        host_write(8'h02, 16'h8000, 1);
        run_list(8'h00, 400);
        check("delay_lat", first_stb_cyc - (t_start + 1), 3 + 3 * DU + 5);

        // Driver held busy while the sequencer waits to issue.
        host_write(8'h40, 16'h0133, 1);
        host_write(8'h41, 16'h8000, 1);
        build_expect(8'h40);
        force_busy = 1'b1;
        s0 = stb_total;
        pulse_start(8'h40);
        repeat (24) begin
            step();
            check("hold_data", {lcd_rs, lcd_data}, 9'h0AA);
        end
        check("hold_nostb", stb_total - s0, 0);
        force_busy = 1'b0;
        base = cyc;
        wait_done(200);
        check("release_lat", first_stb_cyc, base + 1);

        // Host writes are dropped while busy; a start while busy is ignored.
        host_write(8'h20, 16'h1234, 1);
        host_write(8'h50, 16'h4005, 1);
        host_write(8'h51, 16'h0111, 1);
        host_write(8'h52, 16'h8000, 1);
        build_expect(8'h50);
        pulse_start(8'h50);
        host_write(8'h20, 16'hBEEF, 0);
        step();
        start = 1'b1;
        start_addr = 8'h10;
        step();
        start = 1'b0;
        wait_done(400);
        check("drop_mem", mem[8'h20], ref_mem[8'h20]);
        host_write(8'h20, 16'hBEEF, 1);
        step();
        check("land_mem", mem[8'h20], ref_mem[8'h20]);

        // Start and host write in the same idle cycle.
        host_write(8'h61, 16'h8000, 1);
        step();
        host_we = 1'b1;
        host_addr = 8'h60;
        host_data = 16'h0099;
        start = 1'b1;
        start_addr = 8'h60;
        t_start = cyc;
        first_stb_cyc = -1;
        #1;
        check("same_ack", host_ack, 1);
        ref_mem[8'h60] = 16'h0099;
        build_expect(8'h60);
        step();
        host_we = 1'b0;
        start = 1'b0;
        wait_done(200);

        // Reset in the middle of a delay.
        host_write(8'h30, 16'h4003, 1);
        host_write(8'h31, 16'h0077, 1);
        host_write(8'h32, 16'h8000, 1);
        build_expect(8'h30);
        pulse_start(8'h30);
        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_stb", lcd_stb, 0);
        exp_q.delete();
        base = done_cnt;
        s0 = stb_total;
        repeat (50) step();
        check("mid_rst_nodone", done_cnt - base, 0);
        check("mid_rst_nostb", stb_total - s0, 0);
        run_list(8'h30, 400);

        // Random lists with a jittery driver.
        busy_max = 3;
        for (int it = 0; it < 8; it++) begin
            int len;
            sa = 8'($urandom_range(8'h80, 8'hC0));
            len = $urandom_range(1, 10);
            for (int j = 0; j < len; j++) begin
                w = 16'($urandom);
                w[15] = 1'b0;
                w[14] = ($urandom_range(0, 3) == 0);
                if (w[14]) w[11:0] = 12'($urandom_range(0, 2));
                host_write(sa + AW'(j), w, 1);
            end
            host_write(sa + AW'(len), 16'h8000, 1);
            run_list(sa, 2000);
        end

        // No END anywhere: full wrap from 0xFE.
        busy_max = 1;
        for (int i = 0; i < 256; i++) host_write(AW'(i), 16'h0055, 1);
        s0 = stb_total;
        run_list(8'hFE, 20000);
        check("wrap_count", stb_total - s0, 256);

        // A clean run afterwards clears err.
        host_write(8'h10, 16'h0128, 1);
        host_write(8'h11, 16'h8000, 1);
        run_list(8'h10, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hd44780_ram_sequencer.md
Name: hd44780_ram_sequencer

Overview:
Command scheduler that owns the hd44780_ram. It walks a command list stored in the RAM and issues each entry to the HD44780 byte driver as a strobe with an RS bit. It inserts programmed delays and stops on an end marker. It also gates the RAM write port: the host may load the RAM only while the sequencer is idle.

Parameters:
ADDR_WIDTH, 8, RAM address width; matches hd44780_ram addr_width.
DATA_WIDTH, 16, RAM word width; must be >= 16, bits above 15 are ignored.
DELAY_UNIT, 1000, clk cycles per delay tick.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begin executing the list at start_addr
start_addr  in  ADDR_WIDTH  first list address, sampled when start is accepted
busy  out  1  high from the cycle after start is accepted until the list ends
done  out  1  one-cycle pulse when the list ends normally or with an error
err  out  1  set by wrap-around without an END word; cleared by the next accepted start or by reset
ram_raddr  out  ADDR_WIDTH  RAM read address (to hd44780_ram raddr)
ram_dout  in  DATA_WIDTH  RAM read data; valid 1 cycle after ram_raddr is sampled
ram_we  out  1  RAM write enable (to write_en)
ram_waddr  out  ADDR_WIDTH  RAM write address
ram_din  out  DATA_WIDTH  RAM write data
host_we  in  1  host write request
host_addr  in  ADDR_WIDTH  host write address
host_data  in  DATA_WIDTH  host write data
host_ack  out  1  host write accepted this cycle
lcd_stb  out  1  one-cycle strobe to the byte driver
lcd_rs  out  1  register select for the current byte
lcd_data  out  8  byte to send
lcd_busy  in  1  byte driver busy; driver raises it the cycle after lcd_stb

Behaviour:
- Command word format:
  - [15] END: stop; no byte is sent.
  - [14] DELAY: wait [11:0]*DELAY_UNIT cycles; no byte is sent.
  - [8] RS; [7:0] data byte.
  - END takes priority over DELAY. Bits [13:9] are ignored.
- Reset values: busy=0, done=0, err=0, lcd_stb=0, lcd_rs=0, lcd_data=0, ram_raddr=0, pointer=0, delay counter=0, state=IDLE.
- States:
  - IDLE → FETCH on start; pointer <= start_addr, err <= 0.
  - FETCH: drive ram_raddr=pointer → WAIT_RD.
  - WAIT_RD: one cycle for RAM latency → DECODE.
  - DECODE, in priority order:
    - END → DONE.
    - DELAY with count 0 → NEXT.
    - DELAY with count > 0 → DELAY; load the counter with count*DELAY_UNIT-1.
    - otherwise → ISSUE.
  - ISSUE: wait while lcd_busy=1. When lcd_busy=0, pulse lcd_stb for exactly one cycle, latching lcd_rs=[8] and lcd_data=[7:0] → NEXT.
  - DELAY: decrement each cycle; at 0 → NEXT.
  - NEXT: pointer <= pointer+1, modulo 2^ADDR_WIDTH.
    - If the new pointer equals the start address → DONE with err <= 1.
    - otherwise → FETCH.
  - DONE: done=1 for one cycle, busy <= 0 → IDLE.
- Timing: from the start edge to the first lcd_stb is 4 cycles minimum (FETCH, WAIT_RD, DECODE, ISSUE). The per-byte minimum is 5 cycles.
- lcd_rs and lcd_data hold their values until the next strobe.
- start while busy=1 is ignored.
- Write gating, combinational:
  - ram_we = host_we & ~busy; host_ack = ram_we.
  - ram_waddr = host_addr; ram_din = host_data.
  - While busy, host writes are dropped (ack=0). The host must retry.
- start and host_we in the same IDLE cycle: the write is accepted. The first fetch sees the new data because the RAM write completes at the start edge.
- Reset mid-operation: next cycle returns to IDLE, lcd_stb=0, no done pulse.
- The delay product is computed in width 12+clog2(DELAY_UNIT)+1; no overflow.

Test Plan:
- Load RAM[0x10]=0x0128, RAM[0x11]=0x0041, RAM[0x12]=0x8000 with lcd_busy=0, then start with start_addr=0x10 → two strobes: (rs=1, data=0x28) then (rs=0, data=0x41); then done pulse, busy=0, err=0; first strobe 4 cycles after start.
- DELAY_UNIT=10, RAM[0]=0x4003, RAM[1]=0x00AA, RAM[2]=0x8000 → strobe with data=0xAA occurs ≥30 cycles after DECODE of word 0.
- Hold lcd_busy=1 for 20 cycles while the sequencer is in ISSUE → no strobe while busy; strobe on the first cycle lcd_busy=0; lcd_data is stable.
- Fill every address with 0x0055, then start at 0xFE → 256 strobes; pointer wraps 0xFF→0x00; done with err=1.
- host_we with host_addr=0x20 while busy=1 → host_ack=0 and RAM[0x20] is unchanged; the same request when idle → ack=1 and the write lands.
- Assert reset during DELAY → next cycle busy=0, lcd_stb=0, no done; a subsequent start runs normally.
